id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count; x0 hard-wired zero.
REQ-003 SHALL have parameter WB_BYPASS, default 1, write-through from writeback port to same-cycle reads.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  instr/pc valid from IF.
REQ-007 in_ready  output  1  stage accepts instr this cycle.
REQ-008 instr  input  32  RV32I instruction.
REQ-009 pc  input  XLEN  instruction address.
REQ-010 wb_en  input  1  register write enable from WB.
REQ-011 wb_addr  input  $clog2(NUM_REGS)  write address.
REQ-012 wb_data  input  XLEN  write data.
REQ-013 ex_mem_read  input  1  instruction currently in EX is a load.
REQ-014 ex_rd  input  $clog2(NUM_REGS)  destination of that load.
REQ-015 flush  input  1  squash ID/EX contents (taken branch/jump).
REQ-016 out_valid  output  1  ID/EX register holds a live instruction.
REQ-017 out_ready  input  1  EX accepts ID/EX contents.
REQ-018 out_pc, out_rs1_data, out_rs2_data, out_imm  output  XLEN each  registered payload.
REQ-019 out_rs1, out_rs2, out_rd  output  $clog2(NUM_REGS) each  registered addresses.
REQ-020 out_ctrl  output  CTRL_W  packed ctrl_t: alu_type[4], reg_src[2], alu_src1, alu_src2, mem_read, mem_write, reg_write, branch, jal, jalr, branch_type[3], load_type[3], store_type[3].
REQ-021 out_illegal  output  1  registered: opcode not RV32I.
REQ-022 stall  output  1  load-use hazard detected this cycle.

Function
REQ-023 advance SHALL equal (!out_valid || out_ready); ID/EX register updates only when advance=1, else all outputs hold.
REQ-024 hazard SHALL equal in_valid && ex_mem_read && ex_rd!=0 && ((rs1 used && ex_rd==rs1) || (rs2 used && ex_rd==rs2)); U/J types use neither, I/load/JALR use rs1 only.
REQ-025 stall SHALL equal hazard; in_ready SHALL equal advance && !hazard && !flush.
REQ-026 On advance: flush=1 -> out_valid<=0; else hazard=1 -> out_valid<=0 (bubble); else out_valid<=in_valid and payload captured.
REQ-027 flush SHALL take priority over hazard and in_valid; flush while !advance still clears out_valid next edge.
REQ-028 Bubble/flushed entries SHALL carry out_ctrl all-zero (no reg_write, mem_write, branch).
REQ-029 Decode latency SHALL be one cycle: instr accepted at edge N appears on outputs after edge N.
REQ-030 Register file: one write port (wb_en, wb_addr!=0), two combinational read ports; writes to x0 ignored; reads of x0 return 0.
REQ-031 WB_BYPASS=1: read address equal to wb_addr with wb_en=1 and wb_addr!=0 SHALL return wb_data same cycle; WB_BYPASS=0 returns old value.
REQ-032 Immediate SHALL be sign-extended to XLEN per I/S/B/U/J formats; R-type imm=0.
REQ-033 Unknown opcode SHALL produce out_ctrl all-zero and out_illegal=1 with out_valid per REQ-026.
REQ-034 Handshake: transfer IF->ID when in_valid&&in_ready; ID->EX when out_valid&&out_ready; no drop or duplication under any out_ready pattern.

Reset
REQ-035 rst SHALL clear out_valid, out_illegal, out_ctrl, all payload outputs and all NUM_REGS registers to 0 on the next edge.
REQ-036 rst SHALL override flush, hazard and wb_en in the same cycle; in_ready SHALL be 0 while rst=1.

Structure
REQ-037 Package id_pkg SHALL hold ctrl_t, CTRL_W, opcode/funct constants, alu_type/branch_type/load_type/store_type encodings.
REQ-038 Register file SHALL be sub-module id_regfile (parameters XLEN, NUM_REGS, WB_BYPASS); decode and hazard logic inline.

Verification
REQ-039 Reset, then addi x1,x0,5 with out_ready=1 -> next cycle out_valid=1, out_imm=5, out_rd=1, reg_write=1.
REQ-040 EX load ex_rd=3, ID add x4,x3,x2 -> stall=1, in_ready=0, next cycle bubble (out_valid=0); following cycle add issued.
REQ-041 wb_en=1 wb_addr=2 wb_data=0xDEADBEEF same cycle as ID reads x2 -> out_rs2_data=0xDEADBEEF (WB_BYPASS=1).
REQ-042 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; release -> each instruction delivered once in order.
REQ-043 flush=1 together with hazard and valid instr -> out_valid=0, out_ctrl=0; write to x0 then read x0 -> 0; opcode 0x7F -> out_illegal=1.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID/EX stage: opcodes, control encodings
// and the packed control word carried down the pipeline.
package id_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch/load/store types reuse the instruction funct3 encoding directly.
    localparam logic [2:0] BR_EQ  = 3'd0;
    localparam logic [2:0] BR_NE  = 3'd1;
    localparam logic [2:0] BR_LT  = 3'd4;
    localparam logic [2:0] BR_GE  = 3'd5;
    localparam logic [2:0] BR_LTU = 3'd6;
    localparam logic [2:0] BR_GEU = 3'd7;
    localparam logic [2:0] LD_B   = 3'd0;
    localparam logic [2:0] LD_H   = 3'd1;
    localparam logic [2:0] LD_W   = 3'd2;
    localparam logic [2:0] LD_BU  = 3'd4;
    localparam logic [2:0] LD_HU  = 3'd5;
    localparam logic [2:0] ST_B   = 3'd0;
    localparam logic [2:0] ST_H   = 3'd1;
    localparam logic [2:0] ST_W   = 3'd2;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_COPY_B = 4'd10
    } alu_type_e;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_PC4 = 2'd2
    } reg_src_e;

    typedef struct packed {
        alu_type_e  alu_type;
        reg_src_e   reg_src;
        logic       alu_src1;     // 0: rs1, 1: pc
        logic       alu_src2;     // 0: rs2, 1: imm
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [2:0] branch_type;
        logic [2:0] load_type;
        logic [2:0] store_type;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // ALU operation for OP / OP-IMM; SUB only exists in the register form.
    function automatic alu_type_e alu_from_funct(input logic [2:0] f3,
                                                 input logic       alt,
                                                 input logic       is_reg);
        alu_type_e a;
        case (f3)
            F3_ADD_SUB: a = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:     a = ALU_SLL;
            F3_SLT:     a = ALU_SLT;
            F3_SLTU:    a = ALU_SLTU;
            F3_XOR:     a = ALU_XOR;
            F3_SRL_SRA: a = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      a = ALU_OR;
            default:    a = ALU_AND;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Integer register file: one write port, two combinational read ports,
// x0 hard-wired to zero, optional write-through from the write port.
module id_regfile #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr_a,
    output logic [XLEN-1:0] rd_data_a,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [XLEN-1:0] rd_data_b
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] v;
        if (addr == '0)
            v = '0;
        else if ((WB_BYPASS != 0) && wr_en && (wr_addr == addr))
            v = wr_data;
        else
            v = regs_q[addr];
        return v;
    endfunction

    // Next register contents: single write, x0 never written.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != '0))
            regs_d[wr_addr] = wr_data;
    end

    // Register array; reset wins over any concurrent write.
    always_ff @(posedge clk) begin
        if (rst)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;
    end

    assign rd_data_a = read_port(rd_addr_a);
    assign rd_data_b = read_port(rd_addr_b);

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage with ID/EX pipeline register, load-use hazard
// detection and valid/ready handshaking on both sides.
module id_ex_stage
    import id_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   pc,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_mem_read,
    input  logic [AW-1:0]     ex_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [XLEN-1:0]   out_imm,
    output logic [AW-1:0]     out_rs1,
    output logic [AW-1:0]     out_rs2,
    output logic [AW-1:0]     out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_illegal,
    output logic              stall
);

    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [AW-1:0]      rs1_a, rs2_a, rd_a;
    logic [XLEN-1:0]    rs1_rd, rs2_rd;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    ctrl_t              dec_ctrl;
    logic               dec_illegal, use_rs1, use_rs2;
    logic               hazard, advance;

    logic              valid_q, valid_d;
    logic              illegal_q, illegal_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [AW-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign rd_a   = instr[7 +: AW];
    assign rs1_a  = instr[15 +: AW];
    assign rs2_a  = instr[20 +: AW];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    id_regfile #(
        .XLEN      (XLEN),
        .NUM_REGS  (NUM_REGS),
        .WB_BYPASS (WB_BYPASS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data),
        .rd_addr_a (rs1_a),
        .rd_data_a (rs1_rd),
        .rd_addr_b (rs2_a),
        .rd_data_b (rs2_rd)
    );

    // Instruction decode: control word, immediate format and source usage.
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        imm32       = '0;
        case (opcode)
            OP_LUI: begin
                dec_ctrl.alu_type  = ALU_COPY_B;
                dec_ctrl.alu_src2  = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                imm32 = imm_u;
            end
            OP_AUIPC: begin
                dec_ctrl.alu_src1  = 1'b1;
                dec_ctrl.alu_src2  = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                imm32 = imm_u;
            end
            OP_JAL: begin
                dec_ctrl.reg_src   = SRC_PC4;
                dec_ctrl.alu_src1  = 1'b1;
                dec_ctrl.alu_src2  = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jal       = 1'b1;
                imm32 = imm_j;
            end
            OP_JALR: begin
                dec_ctrl.reg_src   = SRC_PC4;
                dec_ctrl.alu_src2  = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jalr      = 1'b1;
                use_rs1 = 1'b1;
                imm32 = imm_i;
            end
            OP_BRANCH: begin
                dec_ctrl.alu_type    = ALU_SUB;
                dec_ctrl.branch      = 1'b1;
                dec_ctrl.branch_type = f3;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32 = imm_b;
            end
            OP_LOAD: begin
                dec_ctrl.reg_src   = SRC_MEM;
                dec_ctrl.alu_src2  = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.load_type = f3;
                use_rs1 = 1'b1;
                imm32 = imm_i;
            end
            OP_STORE: begin
                dec_ctrl.alu_src2   = 1'b1;
                dec_ctrl.mem_write  = 1'b1;
                dec_ctrl.store_type = f3;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32 = imm_s;
            end
            OP_IMM: begin
                dec_ctrl.alu_type  = alu_from_funct(f3, instr[30], 1'b0);
                dec_ctrl.alu_src2  = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                use_rs1 = 1'b1;
                imm32 = imm_i;
            end
            OP_REG: begin
                dec_ctrl.alu_type  = alu_from_funct(f3, instr[30], 1'b1);
                dec_ctrl.reg_write = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            // FENCE and SYSTEM are legal but have no architectural effect here.
            OP_FENCE, OP_SYSTEM: imm32 = imm_i;
            default: dec_illegal = 1'b1;
        endcase
    end

    assign hazard = in_valid && ex_mem_read && (ex_rd != '0) &&
                    ((use_rs1 && (ex_rd == rs1_a)) || (use_rs2 && (ex_rd == rs2_a)));
    assign advance  = !valid_q || out_ready;
    assign stall    = hazard;
    assign in_ready = advance && !hazard && !flush && !rst;

    // ID/EX next state: flush beats hazard beats capture; hold when EX is busy.
    always_comb begin
        valid_d    = valid_q;
        illegal_d  = illegal_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        if (flush || (advance && (hazard || !in_valid))) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            ctrl_d    = '0;
        end else if (advance) begin
            valid_d    = 1'b1;
            illegal_d  = dec_illegal;
            ctrl_d     = dec_ctrl;
            pc_d       = pc;
            rs1_data_d = rs1_rd;
            rs2_data_d = rs2_rd;
            imm_d      = XLEN'(imm32);
            rs1_d      = rs1_a;
            rs2_d      = rs2_a;
            rd_d       = rd_a;
        end
    end

    // ID/EX pipeline register, fully cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            illegal_q  <= illegal_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_illegal  = illegal_q;
    assign out_ctrl     = ctrl_q;
    assign out_pc       = pc_q;
    assign out_rs1_data = rs1_data_q;
    assign out_rs2_data = rs2_data_q;
    assign out_imm      = imm_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_rd       = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: instruction table streamed through a scoreboard,
// plus directed sequences for hazard, bypass, backpressure and flush.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_en, ex_mem_read, flush, out_valid, out_ready;
    logic        out_illegal, stall;
    logic [31:0] instr, pc, wb_data;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  wb_addr, ex_rd, out_rs1, out_rs2, out_rd;
    logic [22:0] out_ctrl;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_ctrl(out_ctrl), .out_illegal(out_illegal), .stall(stall)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [22:0] ctrl;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] pc, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [22:0] ctrl;
        logic        ill;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mreg [32];
    exp_t        sbq [$];
    vec_t        vt [15];
    vec_t        cur_v, v_add;
    logic        accepted, rnd;
    logic [31:0] pc_ctr;

    // Control word: alu[4] reg_src[2] src1 src2 mrd mwr rw br jal jalr bt[3] lt[3] st[3]
    function automatic logic [22:0] mkc(input int alu, rs, s1, s2, mr, mw, rw, br, jl, jr, bt, lt, st);
        return {alu[3:0], rs[1:0], s1[0], s2[0], mr[0], mw[0], rw[0], br[0], jl[0], jr[0],
                bt[2:0], lt[2:0], st[2:0]};
    endfunction

    function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd, op);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1, f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm20, rd, op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    // Reference register read with write-through from the WB port.
    function automatic logic [31:0] rdm(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mreg[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: settle, scoreboard both handshakes, edge, update model.
    task automatic tick();
        exp_t e;
        accepted = 1'b0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        #1;
        if (!rst) begin
            if (out_valid === 1'b1 && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_underflow: output transfer with nothing expected, pc %h", out_pc);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_pc", 64'(out_pc), 64'(e.pc));
                    chk("sb_rs1_data", 64'(out_rs1_data), 64'(e.rs1_data));
                    chk("sb_rs2_data", 64'(out_rs2_data), 64'(e.rs2_data));
                    chk("sb_imm", 64'(out_imm), 64'(e.imm));
                    chk("sb_rs1", 64'(out_rs1), 64'(e.rs1));
                    chk("sb_rs2", 64'(out_rs2), 64'(e.rs2));
                    chk("sb_rd", 64'(out_rd), 64'(e.rd));
                    chk("sb_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                    chk("sb_illegal", 64'(out_illegal), 64'(e.ill));
                end
            end else if (flush && out_valid === 1'b1 && sbq.size() != 0) begin
                void'(sbq.pop_front());
            end
            if (in_valid && in_ready === 1'b1) begin
                e.pc = pc; e.imm = cur_v.imm; e.ctrl = cur_v.ctrl; e.ill = cur_v.ill;
                e.rd = cur_v.instr[11:7]; e.rs1 = cur_v.instr[19:15]; e.rs2 = cur_v.instr[24:20];
                e.rs1_data = rdm(e.rs1); e.rs2_data = rdm(e.rs2);
                sbq.push_back(e);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        if (!rst && wb_en && wb_addr != 5'd0) mreg[wb_addr] = wb_data;
        @(negedge clk);
    endtask

    task automatic send(input vec_t v);
        cur_v = v; instr = v.instr; pc = pc_ctr; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: instr %h never accepted", v.instr);
        end
        in_valid = 1'b0;
        pc_ctr = pc_ctr + 32'd4;
    endtask

    task automatic drain();
        rnd = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sbq.size() == 0 && out_valid !== 1'b1) break;
            tick();
        end
        chk("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        rnd = 1'b0; pc_ctr = 32'h1000;

        vt[0]  = '{enc_i(5, 0, 0, 1, 7'h13), 32'd5, mkc(0,0,0,1,0,0,1,0,0,0,0,0,0), 1'b0};
        vt[1]  = '{enc_i(32'hFFFFFFFF, 1, 0, 5, 7'h13), 32'hFFFFFFFF, mkc(0,0,0,1,0,0,1,0,0,0,0,0,0), 1'b0};
        vt[2]  = '{enc_r(0, 2, 1, 0, 6, 7'h33), 32'd0, mkc(0,0,0,0,0,0,1,0,0,0,0,0,0), 1'b0};
        vt[3]  = '{enc_r(7'h20, 5, 6, 0, 7, 7'h33), 32'd0, mkc(1,0,0,0,0,0,1,0,0,0,0,0,0), 1'b0};
        vt[4]  = '{enc_i(32'h403, 1, 5, 8, 7'h13), 32'h403, mkc(7,0,0,1,0,0,1,0,0,0,0,0,0), 1'b0};
        vt[5]  = '{enc_i(32'hFFFFFFFC, 2, 2, 9, 7'h03), 32'hFFFFFFFC, mkc(0,1,0,1,1,0,1,0,0,0,0,2,0), 1'b0};
        vt[6]  = '{enc_s(8, 3, 4, 2), 32'd8, mkc(0,0,0,1,0,1,0,0,0,0,0,0,2), 1'b0};
        vt[7]  = '{enc_b(32'hFFFFFFF8, 2, 1, 1), 32'hFFFFFFF8, mkc(1,0,0,0,0,0,0,1,0,0,1,0,0), 1'b0};
        vt[8]  = '{enc_u(32'h12345, 10, 7'h37), 32'h12345000, mkc(10,0,0,1,0,0,1,0,0,0,0,0,0), 1'b0};
        vt[9]  = '{enc_u(32'h80000, 11, 7'h17), 32'h80000000, mkc(0,0,1,1,0,0,1,0,0,0,0,0,0), 1'b0};
        vt[10] = '{enc_j(32'hFFF00000, 1), 32'hFFF00000, mkc(0,2,1,1,0,0,1,0,1,0,0,0,0), 1'b0};
        vt[11] = '{enc_i(0, 1, 0, 0, 7'h67), 32'd0, mkc(0,2,0,1,0,0,1,0,0,1,0,0,0), 1'b0};
        vt[12] = '{32'h0000007F, 32'd0, 23'd0, 1'b1};
        vt[13] = '{enc_i(32'h800, 4, 2, 12, 7'h13), 32'hFFFFF800, mkc(3,0,0,1,0,0,1,0,0,0,0,0,0), 1'b0};
        vt[14] = '{enc_i(32'h7FF, 3, 4, 1, 7'h03), 32'd2047, mkc(0,1,0,1,1,0,1,0,0,0,0,4,0), 1'b0};
        v_add  = '{enc_r(0, 2, 3, 0, 4, 7'h33), 32'd0, mkc(0,0,0,0,0,0,1,0,0,0,0,0,0), 1'b0};

        // Reset asserted with valid input, flush and a WB write all pending.
        rst = 1'b1; in_valid = 1'b1; instr = vt[0].instr; pc = 32'h40; out_ready = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55; flush = 1'b1;
        ex_mem_read = 1'b0; ex_rd = 5'd0; cur_v = vt[0];
        @(negedge clk);
        #1 chk("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        #1 chk("rst_in_ready2", 64'(in_ready), 64'd0);
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0;

        // First instruction after reset: addi x1,x0,5.
        send(vt[0]);
        #1;
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_imm", 64'(out_imm), 64'd5);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_reg_write", 64'(out_ctrl[12]), 64'd1);
        drain();

        wb_write(5'd1, 32'h11);
        wb_write(5'd2, 32'h100);
        wb_write(5'd3, 32'h33);
        wb_write(5'd4, 32'h44);

        // Table pass with EX always ready.
        for (int i = 0; i < 15; i++) send(vt[i]);
        drain();

        // Load-use: a bubble is inserted behind the departing instruction.
        send(vt[0]);
        cur_v = v_add; instr = v_add.instr; pc = pc_ctr; in_valid = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd3;
        #1;
        chk("lu_stall", 64'(stall), 64'd1);
        chk("lu_in_ready", 64'(in_ready), 64'd0);
        tick();
        ex_mem_read = 1'b0;
        #1;
        chk("lu_bubble_valid", 64'(out_valid), 64'd0);
        chk("lu_bubble_ctrl", 64'(out_ctrl), 64'd0);
        chk("lu_reissue_ready", 64'(in_ready), 64'd1);
        send(v_add);
        drain();

        // Hazard boundaries: x0 never hazards, unused source fields are ignored.
        ex_mem_read = 1'b1;
        ex_rd = 5'd0; instr = enc_r(0, 0, 0, 0, 4, 7'h33); in_valid = 1'b1;
        #1 chk("hz_x0", 64'(stall), 64'd0);
        @(negedge clk);
        ex_rd = 5'd8; instr = vt[8].instr;
        #1 chk("hz_lui_unused", 64'(stall), 64'd0);
        @(negedge clk);
        ex_rd = 5'd28; instr = vt[5].instr;
        #1 chk("hz_load_rs2_unused", 64'(stall), 64'd0);
        @(negedge clk);
        ex_rd = 5'd3; instr = vt[6].instr;
        #1 chk("hz_store_rs2", 64'(stall), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; ex_mem_read = 1'b0;
        #1 chk("hz_no_valid", 64'(stall), 64'd0);
        @(negedge clk);

        // Write-through of a same-cycle WB write, and x0 stays zero.
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEADBEEF;
        send('{enc_r(0, 2, 1, 0, 12, 7'h33), 32'd0, mkc(0,0,0,0,0,0,1,0,0,0,0,0,0), 1'b0});
        wb_en = 1'b0;
        #1 chk("byp_rs2_data", 64'(out_rs2_data), 64'hDEADBEEF);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        send('{enc_r(0, 0, 0, 0, 14, 7'h33), 32'd0, mkc(0,0,0,0,0,0,1,0,0,0,0,0,0), 1'b0});
        wb_en = 1'b0;
        #1 chk("x0_same_cycle", 64'(out_rs1_data), 64'd0);
        send('{enc_i(0, 0, 0, 13, 7'h13), 32'd0, mkc(0,0,0,1,0,0,1,0,0,0,0,0,0), 1'b0});
        #1 chk("x0_after_write", 64'(out_rs1_data), 64'd0);
        send(vt[12]);
        #1 chk("illegal_flag", 64'(out_illegal), 64'd1);
        drain();

        // Backpressure: EX stalls three cycles, contents hold.
        out_ready = 1'b0;
        send(vt[1]);
        cur_v = vt[2]; instr = vt[2].instr; pc = pc_ctr; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_pc", 64'(out_pc), 64'(sbq[0].pc));
            chk("bp_hold_imm", 64'(out_imm), 64'(sbq[0].imm));
            tick();
        end
        out_ready = 1'b1;
        send(vt[2]);
        send(vt[3]);
        drain();

        // Flush wins over hazard and valid input.
        send(vt[0]);
        cur_v = v_add; instr = enc_r(0, 2, 1, 0, 4, 7'h33); in_valid = 1'b1; pc = pc_ctr;
        ex_mem_read = 1'b1; ex_rd = 5'd1; flush = 1'b1;
        #1;
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        chk("fl_stall", 64'(stall), 64'd1);
        tick();
        flush = 1'b0; ex_mem_read = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_ctrl", 64'(out_ctrl), 64'd0);
        // Flush while EX is stalled still squashes.
        send(vt[4]);
        out_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_stalled_valid", 64'(out_valid), 64'd0);
        drain();

        // Table pass under random EX backpressure.
        rnd = 1'b1;
        for (int i = 0; i < 15; i++) send(vt[i]);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
